// File: rtl/freq_meter_pkg.sv
// Types shared by the frequency meter and its helpers.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by a
// one-cycle rising-edge pulse generator.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate
// windows of GATE_CYCLES clocks and reports each completed window.
module frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int FREQUENCY_IN = 50_000_000,
    parameter int GATE_CYCLES  = FREQUENCY_IN,
    parameter int COUNT_WIDTH  = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sigIn,
    output logic [COUNT_WIDTH-1:0] freqCount,
    output logic                   valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int                     GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    meter_state_t           state_q, state_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] freq_q, freq_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;

    logic                   edge_pulse;
    logic [COUNT_WIDTH-1:0] edge_cnt_acc;
    logic                   sat_acc;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(sigIn),
        .rise    (edge_pulse)
    );

    // Edge count including this cycle's edge; sticks at all-ones once reached.
    always_comb begin
        edge_cnt_acc = edge_cnt_q;
        if (edge_pulse && (edge_cnt_q != COUNT_MAX)) begin
            edge_cnt_acc = edge_cnt_q + COUNT_WIDTH'(1);
        end
        sat_acc = sat_q | (edge_cnt_acc == COUNT_MAX);
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // Window closes; counters restart in the same cycle so no clock is lost.
                    valid_d = 1'b1;
                    freq_d  = edge_cnt_acc;
                    ovf_d   = sat_acc;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_cnt_acc;
                    sat_d      = sat_acc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign freqCount = freq_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == MEASURE);

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: a 32-bit instance and a 4-bit
// instance share every input so saturation can be seen alongside the full count.
module tb_frequency_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic [31:0] freq32;
    logic        valid32, ovf32, busy32;
    logic [3:0]  freq4;
    logic        valid4, ovf4, busy4;

    int total = 0;
    int bad   = 0;
    int period = 0;
    int phase  = 0;
    int rises  = 0;
    int n;
    int sum;
    int vseen;

    always #5 clk = ~clk;

    frequency_meter #(
        .FREQUENCY_IN(100), .GATE_CYCLES(100), .COUNT_WIDTH(32), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sigIn(sig_in),
        .freqCount(freq32), .valid(valid32), .overflow(ovf32), .busy(busy32)
    );

    frequency_meter #(
        .FREQUENCY_IN(100), .GATE_CYCLES(100), .COUNT_WIDTH(4), .SYNC_STAGES(2)
    ) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .sigIn(sig_in),
        .freqCount(freq4), .valid(valid4), .overflow(ovf4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample point is 1 ns after the edge, where the pattern also advances.
    task automatic tick();
        logic nv;
        @(posedge clk);
        #1;
        if (period != 0) begin
            nv = (phase < period / 2);
            if (nv && !sig_in) rises++;
            sig_in = nv;
            phase = (phase + 1 == period) ? 0 : phase + 1;
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!valid32 && cnt < maxc);
        if (!valid32) chk({tag, "_timeout"}, {31'b0, valid32}, 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        tick();
        tick();
        chk("rst_freq", freq32, 32'd0);
        chk("rst_valid", {31'b0, valid32}, 32'd0);
        chk("rst_ovf", {31'b0, ovf32}, 32'd0);
        chk("rst_busy", {31'b0, busy32}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'b0, busy32}, 32'd0);
        $display("step reset: freq=%0d busy=%0d", freq32, busy32);

        // 1: period-10 square wave, windows every 100 clocks
        enable = 1'b1;
        period = 10;
        phase  = 0;
        wait_valid("t1_first", 250, n);
        chk("t1_busy", {31'b0, busy32}, 32'd1);
        for (int w = 0; w < 3; w++) begin
            wait_valid("t1_win", 150, n);
            chk("t1_spacing", 32'(n), 32'd100);
            chk("t1_freq", freq32, 32'd10);
            chk("t1_ovf", {31'b0, ovf32}, 32'd0);
            $display("step t1 window %0d: spacing=%0d freq=%0d ovf=%0d", w, n, freq32, ovf32);
        end

        // 2: held low, single rise, held high
        period = 0;
        sig_in = 1'b0;
        wait_valid("t2_drain", 150, n);
        wait_valid("t2_low", 150, n);
        chk("t2_low_freq", freq32, 32'd0);
        chk("t2_low_freq4", {28'b0, freq4}, 32'd0);
        $display("step t2 low: freq=%0d", freq32);
        sig_in = 1'b1;
        wait_valid("t2_rise", 150, n);
        chk("t2_rise_freq", freq32, 32'd1);
        wait_valid("t2_high", 150, n);
        chk("t2_high_freq", freq32, 32'd0);
        chk("t2_high_ovf", {31'b0, ovf32}, 32'd0);
        $display("step t2 high: freq=%0d", freq32);

        // 3: 25 edges per window saturate the 4-bit instance
        period = 4;
        phase  = 0;
        wait_valid("t3_drain", 150, n);
        wait_valid("t3_fast", 150, n);
        chk("t3_freq32", freq32, 32'd25);
        chk("t3_freq4", {28'b0, freq4}, 32'd15);
        chk("t3_ovf4", {31'b0, ovf4}, 32'd1);
        chk("t3_ovf32", {31'b0, ovf32}, 32'd0);
        $display("step t3 fast: freq32=%0d freq4=%0d ovf4=%0d", freq32, freq4, ovf4);
        period = 10;
        phase  = 0;
        wait_valid("t3_drain2", 150, n);
        wait_valid("t3_slow", 150, n);
        chk("t3_slow_freq4", {28'b0, freq4}, 32'd10);
        chk("t3_slow_ovf4", {31'b0, ovf4}, 32'd0);
        chk("t3_slow_freq32", freq32, 32'd10);
        $display("step t3 slow: freq4=%0d ovf4=%0d", freq4, ovf4);

        // 4: abort at gate cycle 50, then a full window after re-enable
        repeat (50) tick();
        enable = 1'b0;
        tick();
        chk("t4_busy", {31'b0, busy32}, 32'd0);
        vseen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid32) vseen++;
        end
        chk("t4_no_valid", 32'(vseen), 32'd0);
        chk("t4_hold_freq", freq32, 32'd10);
        $display("step t4 abort: busy=%0d valids=%0d freq=%0d", busy32, vseen, freq32);
        enable = 1'b1;
        wait_valid("t4_restart", 200, n);
        chk("t4_restart_lat", 32'(n), 32'd101);
        chk("t4_restart_freq", freq32, 32'd10);
        $display("step t4 restart: latency=%0d freq=%0d", n, freq32);

        // 5: asynchronous reset mid-window
        repeat (30) tick();
        reset = 1'b1;
        #1;
        chk("t5_freq", freq32, 32'd0);
        chk("t5_freq4", {28'b0, freq4}, 32'd0);
        chk("t5_valid", {31'b0, valid32}, 32'd0);
        chk("t5_busy", {31'b0, busy32}, 32'd0);
        $display("step t5 reset: freq=%0d busy=%0d", freq32, busy32);
        tick();
        tick();
        reset = 1'b0;
        wait_valid("t5_after", 200, n);
        chk("t5_lat", 32'(n), 32'd101);
        chk("t5_ovf", {31'b0, ovf32}, 32'd0);
        $display("step t5 release: latency=%0d", n);

        // 6: rise landing on the last gate cycle belongs to that window
        period = 0;
        sig_in = 1'b0;
        wait_valid("t6_drain", 150, n);
        wait_valid("t6_clean", 150, n);
        chk("t6_clean_freq", freq32, 32'd0);
        repeat (97) tick();
        sig_in = 1'b1;
        wait_valid("t6_last", 150, n);
        chk("t6_last_gap", 32'(n), 32'd3);
        chk("t6_last_freq", freq32, 32'd1);
        wait_valid("t6_next", 150, n);
        chk("t6_next_freq", freq32, 32'd0);
        $display("step t6 last-cycle edge: next window freq=%0d", freq32);

        // 6b: ten back-to-back windows lose no edges
        sig_in = 1'b0;
        wait_valid("t6_drain2", 150, n);
        rises  = 0;
        sum    = 0;
        period = 7;
        phase  = 0;
        for (int w = 0; w < 9; w++) begin
            wait_valid("t6_b2b", 150, n);
            chk("t6_b2b_spacing", 32'(n), 32'd100);
            sum += int'(freq32);
            $display("step t6 window %0d: freq=%0d", w, freq32);
        end
        repeat (90) tick();
        period = 0;
        sig_in = 1'b0;
        wait_valid("t6_b2b_last", 150, n);
        sum += int'(freq32);
        chk("t6_b2b_sum", 32'(sum), 32'(rises));
        $display("step t6 window 9: freq=%0d sum=%0d driven=%0d", freq32, sum, rises);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
